goertzel_core: RTL and testbench
================================

GOERTZEL_CORE -- requirements
Module: goertzel_core

Interface
REQ-001 The block SHALL take parameter N, default 205: samples per Goertzel block, range 2..65535.
REQ-002 The block SHALL take parameter COEF, default 16'sd27980: signed Q2.14 coefficient 2*cos(2*pi*k/N).
REQ-003 The block SHALL take parameter SW, default 32: width of the signed state registers s1/s2.
REQ-004 The block SHALL have the following ports, with one clock and an asynchronous active-low reset:
- clk  input  1  rising-edge clock.
- nrst  input  1  asynchronous active-low reset.
- valid  input  1  upstream sample valid.
- sample  input  8  unsigned offset-binary ADC sample; 128 = zero.
- ready  output  1  core can accept a sample this cycle.
- power  output  64  unsigned Goertzel power of the last completed block.
- res_valid  output  1  one-cycle pulse when power updates.
- busy  output  1  high while in the FIN or OUT state.

Function
REQ-005 The core SHALL run a state machine with states ACC, FIN0, FIN1, FIN2 and OUT; the reset state is ACC.
REQ-006 In ACC, ready SHALL be 1; a sample is accepted on the rising edge where valid and ready are both 1, and valid without ready SHALL be ignored.
REQ-007 On each accepted sample, x = sample - 128 SHALL be formed as a signed 9-bit value.
REQ-008 On each accepted sample, the same edge SHALL update s1 <= x + ((COEF*s1) >>> 14) - s2 and s2 <= s1:
- arithmetic is full-precision signed;
- the >>> is an arithmetic shift that truncates toward minus infinity;
- the result is truncated to SW bits and wraps in two's complement without saturation.
REQ-009 A sample counter SHALL increment per accepted sample; the edge accepting the Nth sample SHALL move the state to FIN0, and ready SHALL be 0 from the next cycle.
REQ-010 FIN0 SHALL register p_a = s1*s1; FIN1 SHALL register p_b = s2*s2; FIN2 SHALL register p_c = (COEF*s1*s2) >>> 14. All three are 64-bit signed.
REQ-011 In OUT, power SHALL load p_a + p_b - p_c, clamped to 0 if negative, and res_valid SHALL be 1 for exactly this cycle.
REQ-012 In OUT, s1, s2 and the counter SHALL clear to 0, and the next state SHALL be ACC.
REQ-013 Latency from the edge accepting the Nth sample to res_valid high SHALL be 4 cycles, and ready SHALL be low for exactly 4 cycles (FIN0..OUT).
REQ-014 Gaps in valid SHALL not affect the result; only accepted samples count.
REQ-015 Between results, power SHALL hold its last value.
REQ-016 A sample presented while ready=0 SHALL NOT be consumed; upstream holds valid and sample until accepted.
REQ-017 busy SHALL equal 1 exactly when the state is FIN0, FIN1, FIN2 or OUT.
REQ-018 Counter wrap SHALL NOT occur, because the counter resets at N and is sized ceil(log2(N+1)) bits.

Reset
REQ-019 Asserting nrst low SHALL immediately, and asynchronously, force:
- state = ACC;
- s1 = s2 = 0, counter = 0, p_a = p_b = p_c = 0;
- power = 0, res_valid = 0, busy = 0.
REQ-020 While nrst is low, ready SHALL read 1, since state is ACC; samples are not accepted until nrst is sampled high.
REQ-021 Reset asserted mid-block or during FIN/OUT SHALL discard the partial block with no res_valid pulse; the first block after release starts from sample 1.
REQ-022 The nrst input is already synchronized upstream; the core SHALL NOT add a reset synchronizer.

Verification
REQ-023 Reset check: drive nrst=0 with random inputs -> power=0, res_valid=0, busy=0, ready=1; after release with valid=0, all outputs remain unchanged for 100 cycles.
REQ-024 On-bin check (N=4, COEF=0): send samples 129,128,127,128 back-to-back -> res_valid pulses 4 cycles after the 4th accept with power=4 (s1=0, s2=-2).
REQ-025 DC/off-bin check (N=4, COEF=0): send four samples of 129 -> power=0. Then send four samples of 128 -> power=0, with res_valid pulsed twice in total.
REQ-026 Back-pressure check: hold valid=1 continuously for 3 blocks (N=4) -> ready low exactly 4 cycles per block, no sample lost, all 3 results match the reference model.
REQ-027 Gap and mid-block reset check: insert random valid gaps -> result identical to the no-gap run. Pulse nrst low after 2 of 4 samples -> no res_valid; the next full block gives the correct power.
REQ-028 Default-parameter check (N=205, COEF=27980): send a sine at bin k versus at bin k+3 (amplitude 100, offset 128) -> on-bin power exceeds off-bin by at least 40 dB, and power matches a bit-accurate model exactly.

Source files
------------

// File: rtl/goertzel_core.sv
// Single-bin Goertzel detector for an 8-bit offset-binary ADC stream.
// Accumulates N samples through the second-order resonator, then spends
// four cycles (FIN0..OUT) forming the block power before restarting.
module goertzel_core #(
  parameter int unsigned        N    = 205,
  parameter logic signed [15:0] COEF = 16'sd27980,
  parameter int unsigned        SW   = 32
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        valid,
  input  logic [7:0]  sample,
  output logic        ready,
  output logic [63:0] power,
  output logic        res_valid,
  output logic        busy
);

  localparam int unsigned   CW       = $clog2(N + 1);
  localparam int unsigned   AW       = SW + 18;
  localparam int unsigned   PW       = (2 * SW + 16 > 66) ? 2 * SW + 16 : 66;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [2:0] {ACC, FIN0, FIN1, FIN2, OUT} state_t;

  state_t state, state_nx;

  logic signed [SW-1:0] s1, s2;
  logic [CW-1:0]        cnt;
  logic signed [63:0]   p_a, p_b, p_c;
  logic                 accept;

  logic signed [8:0]    x;
  logic signed [AW-1:0] x_w, s1_w, s2_w, coef_w, s1_nx_w;
  logic signed [PW-1:0] s1_p, s2_p, coef_p, sq1_p, sq2_p, cross_p;
  logic signed [63:0]   p_c_nx;
  logic signed [65:0]   pwr_sum;
  logic                 unused_bits;

  assign x = $signed({1'b0, sample}) - 9'sd128;

  // Recursion datapath at full precision, wrapped to SW bits on store.
  assign x_w     = {{(AW-9){x[8]}}, x};
  assign s1_w    = {{(AW-SW){s1[SW-1]}}, s1};
  assign s2_w    = {{(AW-SW){s2[SW-1]}}, s2};
  assign coef_w  = {{(AW-16){COEF[15]}}, COEF};
  assign s1_nx_w = x_w + ((coef_w * s1_w) >>> 14) - s2_w;

  // Power-term products, wide enough that nothing is lost before truncation to 64 bits.
  assign s1_p    = {{(PW-SW){s1[SW-1]}}, s1};
  assign s2_p    = {{(PW-SW){s2[SW-1]}}, s2};
  assign coef_p  = {{(PW-16){COEF[15]}}, COEF};
  assign sq1_p   = s1_p * s1_p;
  assign sq2_p   = s2_p * s2_p;
  assign cross_p = (coef_p * s1_p * s2_p) >>> 14;
  assign p_c_nx  = cross_p[63:0];

  // Cross term enters straight from the multiplier so power is already
  // valid during OUT, the same cycle res_valid is high.
  assign pwr_sum = {{2{p_a[63]}}, p_a} + {{2{p_b[63]}}, p_b} - {{2{p_c_nx[63]}}, p_c_nx};

  assign accept = valid & ready;

  assign unused_bits = ^{s1_nx_w[AW-1:SW], sq1_p[PW-1:64], sq2_p[PW-1:64],
                         cross_p[PW-1:64], p_c};

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= ACC;
    else       state <= state_nx;
  end

  // Next-state logic plus handshake/status outputs.
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    busy     = 1'b0;
    case (state)
      ACC: begin
        ready = 1'b1;
        if (valid && (cnt == CNT_LAST)) state_nx = FIN0;
      end
      FIN0: begin
        busy     = 1'b1;
        state_nx = FIN1;
      end
      FIN1: begin
        busy     = 1'b1;
        state_nx = FIN2;
      end
      FIN2: begin
        busy     = 1'b1;
        state_nx = OUT;
      end
      OUT: begin
        busy     = 1'b1;
        state_nx = ACC;
      end
      default: state_nx = ACC;
    endcase
  end

  // Resonator state, sample counter, power terms and result register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1        <= '0;
      s2        <= '0;
      cnt       <= '0;
      p_a       <= '0;
      p_b       <= '0;
      p_c       <= '0;
      power     <= '0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        ACC: begin
          if (accept) begin
            s1  <= s1_nx_w[SW-1:0];
            s2  <= s1;
            cnt <= cnt + CW'(1);
          end
        end
        FIN0: p_a <= sq1_p[63:0];
        FIN1: p_b <= sq2_p[63:0];
        FIN2: begin
          p_c       <= p_c_nx;
          power     <= pwr_sum[65] ? '0 : pwr_sum[63:0];
          res_valid <= 1'b1;
        end
        OUT: begin
          s1  <= '0;
          s2  <= '0;
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_goertzel_core.sv
// Bench for goertzel_core: a small N=4/COEF=0 instance for handshake and
// reset behaviour, and a default-parameter instance for the tone test.
module tb_goertzel_core;

  logic        clk = 1'b0;
  logic        nrst;
  logic        vs, vd;
  logic [7:0]  ss, sd;
  logic        ready_s, rv_s, busy_s, ready_d, rv_d, busy_d;
  logic [63:0] power_s, power_d;

  int vectors     = 0;
  int miscompares = 0;
  int rvc_s = 0, rvc_d = 0, acc_s = 0, run_s = 0;
  int runs_s[$];
  logic [63:0] pq_s[$];

  always #5 clk = ~clk;

  goertzel_core #(.N(4), .COEF(16'sd0), .SW(32)) dut_s (
    .clk(clk), .nrst(nrst), .valid(vs), .sample(ss),
    .ready(ready_s), .power(power_s), .res_valid(rv_s), .busy(busy_s)
  );

  goertzel_core dut_d (
    .clk(clk), .nrst(nrst), .valid(vd), .sample(sd),
    .ready(ready_d), .power(power_d), .res_valid(rv_d), .busy(busy_d)
  );

  // Event monitor: accepts, result pulses and lengths of ready-low runs.
  always @(negedge clk) begin
    if (nrst !== 1'b1) run_s = 0;
    else begin
      if (vs && ready_s) acc_s++;
      if (rv_s) begin rvc_s++; pq_s.push_back(power_s); end
      if (rv_d) rvc_d++;
      if (!ready_s) run_s++;
      else if (run_s != 0) begin runs_s.push_back(run_s); run_s = 0; end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  // Goertzel reference: plain integer recursion with SW=32 wrap, then power.
  function automatic logic [63:0] ref_power(input int coef, input logic [7:0] blk[$]);
    int s1 = 0, s2 = 0;
    longint t;
    logic signed [127:0] a, b, sum;
    logic signed [63:0]  c64;
    foreach (blk[i]) begin
      t  = longint'(int'(blk[i]) - 128) + ((longint'(coef) * longint'(s1)) >>> 14) - longint'(s2);
      s2 = s1;
      s1 = int'(t);
    end
    a   = 128'(s1) * 128'(s1);
    b   = 128'(s2) * 128'(s2);
    c64 = 64'((128'(coef) * 128'(s1) * 128'(s2)) >>> 14);
    sum = a + b - 128'(c64);
    return (sum < 0) ? 64'd0 : sum[63:0];
  endfunction

  // Present one sample (optionally after a gap); caller is at posedge+1.
  // Returns at posedge+1 of the accepting edge with valid still high.
  task automatic send(input bit dflt, input logic [7:0] smp, input int gap);
    bit done = 1'b0;
    if (gap > 0) begin
      if (dflt) vd = 1'b0; else vs = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    if (dflt) begin vd = 1'b1; sd = smp; end
    else      begin vs = 1'b1; ss = smp; end
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if ((dflt ? ready_d : ready_s) === 1'b1) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL send_timeout: sample %0d not accepted within 50 cycles", smp);
    end
  endtask

  // Wait until the result counter reaches target; ends at posedge+1.
  task automatic wait_res(input bit dflt, input int target);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk); #1;
      if ((dflt ? rvc_d : rvc_s) >= target) done = 1'b1;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL res_timeout: got %0d results, required %0d", dflt ? rvc_d : rvc_s, target);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3 nrst = 1'b0;
    #1;
    vectors += 2;
    if ({power_s, rv_s, busy_s, ready_s} !== {64'd0, 3'b001}) begin
      miscompares++;
      $display("FAIL reset_async_s: power=%0d rv=%b busy=%b ready=%b, required 0 0 0 1", power_s, rv_s, busy_s, ready_s);
    end
    if ({power_d, rv_d, busy_d, ready_d} !== {64'd0, 3'b001}) begin
      miscompares++;
      $display("FAIL reset_async_d: power=%0d rv=%b busy=%b ready=%b, required 0 0 0 1", power_d, rv_d, busy_d, ready_d);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      vs = 1'($urandom); ss = 8'($urandom); vd = 1'($urandom); sd = 8'($urandom);
      @(negedge clk);
      vectors += 2;
      if ({power_s, rv_s, busy_s, ready_s} !== {64'd0, 3'b001}) begin
        miscompares++;
        $display("FAIL reset_hold_s: power=%0d rv=%b busy=%b ready=%b, required 0 0 0 1", power_s, rv_s, busy_s, ready_s);
      end
      if ({power_d, rv_d, busy_d, ready_d} !== {64'd0, 3'b001}) begin
        miscompares++;
        $display("FAIL reset_hold_d: power=%0d rv=%b busy=%b ready=%b, required 0 0 0 1", power_d, rv_d, busy_d, ready_d);
      end
    end
    vs = 1'b0; vd = 1'b0;
    nrst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      vectors += 2;
      if ({power_s, rv_s, busy_s, ready_s} !== {64'd0, 3'b001}) begin
        miscompares++;
        $display("FAIL idle_s: power=%0d rv=%b busy=%b ready=%b, required 0 0 0 1", power_s, rv_s, busy_s, ready_s);
      end
      if ({power_d, rv_d, busy_d, ready_d} !== {64'd0, 3'b001}) begin
        miscompares++;
        $display("FAIL idle_d: power=%0d rv=%b busy=%b ready=%b, required 0 0 0 1", power_d, rv_d, busy_d, ready_d);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_on_bin();
    logic [7:0] blk[$] = '{8'd129, 8'd128, 8'd127, 8'd128};
    logic [63:0] exp = ref_power(0, blk);
    foreach (blk[i]) send(1'b0, blk[i], 0);
    vs = 1'b0;
    // FIN0, FIN1, FIN2, OUT: ready low, busy high, result in the fourth cycle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({ready_s, busy_s, rv_s} !== {1'b0, 1'b1, (i == 3)}) begin
        miscompares++;
        $display("FAIL on_bin_timing[%0d]: ready=%b busy=%b rv=%b, required 0 1 %0d", i, ready_s, busy_s, rv_s, i == 3);
      end
    end
    vectors += 2;
    if (power_s !== 64'd4) begin
      miscompares++;
      $display("FAIL on_bin_power: got %0d, required 4", power_s);
    end
    if (power_s !== exp) begin
      miscompares++;
      $display("FAIL on_bin_model: got %0d, required %0d", power_s, exp);
    end
    @(negedge clk);
    vectors++;
    if ({ready_s, busy_s, rv_s, power_s} !== {3'b100, 64'd4}) begin
      miscompares++;
      $display("FAIL on_bin_after: ready=%b busy=%b rv=%b power=%0d, required 1 0 0 4", ready_s, busy_s, rv_s, power_s);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_dc_off_bin();
    int r0 = rvc_s;
    for (int i = 0; i < 4; i++) send(1'b0, 8'd129, 0);
    vs = 1'b0;
    wait_res(1'b0, r0 + 1);
    vectors++;
    if (power_s !== 64'd0) begin
      miscompares++;
      $display("FAIL dc_power: got %0d, required 0", power_s);
    end
    for (int i = 0; i < 4; i++) send(1'b0, 8'd128, 0);
    vs = 1'b0;
    wait_res(1'b0, r0 + 2);
    repeat (3) @(posedge clk);
    #1;
    vectors += 2;
    if (power_s !== 64'd0) begin
      miscompares++;
      $display("FAIL zero_power: got %0d, required 0", power_s);
    end
    if (rvc_s - r0 !== 2) begin
      miscompares++;
      $display("FAIL dc_pulses: got %0d, required 2", rvc_s - r0);
    end
  endtask

  task automatic test_back_pressure();
    logic [7:0]  all[$];
    logic [7:0]  chunk[$];
    logic [63:0] expv[3];
    int r0 = rvc_s, a0 = acc_s, nr0 = runs_s.size(), np;
    for (int b = 0; b < 3; b++) begin
      chunk = {};
      for (int i = 0; i < 4; i++) chunk.push_back(8'($urandom));
      expv[b] = ref_power(0, chunk);
      foreach (chunk[i]) all.push_back(chunk[i]);
    end
    foreach (all[i]) send(1'b0, all[i], 0);
    vs = 1'b0;
    wait_res(1'b0, r0 + 3);
    repeat (2) @(posedge clk);
    #1;
    vectors += 3;
    if (acc_s - a0 !== 12) begin
      miscompares++;
      $display("FAIL bp_accepts: got %0d, required 12", acc_s - a0);
    end
    if (rvc_s - r0 !== 3) begin
      miscompares++;
      $display("FAIL bp_results: got %0d, required 3", rvc_s - r0);
    end
    if (runs_s.size() - nr0 !== 3) begin
      miscompares++;
      $display("FAIL bp_runs: got %0d ready-low runs, required 3", runs_s.size() - nr0);
    end
    np = pq_s.size();
    for (int b = 0; b < 3; b++) begin
      vectors += 2;
      if (runs_s.size() > nr0 + b && runs_s[nr0 + b] !== 4) begin
        miscompares++;
        $display("FAIL bp_ready_low[%0d]: got %0d cycles, required 4", b, runs_s[nr0 + b]);
      end
      if (np < 3 || pq_s[np - 3 + b] !== expv[b]) begin
        miscompares++;
        $display("FAIL bp_power[%0d]: got %0d, required %0d", b, (np < 3) ? 64'd0 : pq_s[np - 3 + b], expv[b]);
      end
    end
  endtask

  task automatic test_gaps_reset();
    logic [7:0]  blk[$];
    logic [63:0] exp, p1;
    int r0;
    for (int i = 0; i < 4; i++) blk.push_back(8'($urandom));
    exp = ref_power(0, blk);
    r0  = rvc_s;
    foreach (blk[i]) send(1'b0, blk[i], 0);
    vs = 1'b0;
    wait_res(1'b0, r0 + 1);
    p1 = power_s;
    vectors++;
    if (p1 !== exp) begin
      miscompares++;
      $display("FAIL nogap_power: got %0d, required %0d", p1, exp);
    end
    foreach (blk[i]) send(1'b0, blk[i], int'($urandom_range(1, 4)));
    vs = 1'b0;
    wait_res(1'b0, r0 + 2);
    vectors++;
    if (power_s !== exp) begin
      miscompares++;
      $display("FAIL gap_power: got %0d, required %0d", power_s, exp);
    end
    // Reset after two of four samples.
    r0 = rvc_s;
    send(1'b0, 8'($urandom), 0);
    send(1'b0, 8'($urandom), 0);
    vs = 1'b0;
    @(posedge clk); #3 nrst = 1'b0;
    #1;
    vectors++;
    if ({power_s, busy_s, ready_s} !== {64'd0, 2'b01}) begin
      miscompares++;
      $display("FAIL midblk_reset: power=%0d busy=%b ready=%b, required 0 0 1", power_s, busy_s, ready_s);
    end
    @(negedge clk); nrst = 1'b1;
    // Reset while the block is in FIN1.
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send(1'b0, 8'($urandom), 0);
    vs = 1'b0;
    @(posedge clk); #3;
    vectors++;
    if (busy_s !== 1'b1) begin
      miscompares++;
      $display("FAIL fin_busy: got %b, required 1", busy_s);
    end
    nrst = 1'b0;
    #1;
    vectors++;
    if ({busy_s, ready_s, rv_s} !== 3'b010) begin
      miscompares++;
      $display("FAIL fin_reset: busy=%b ready=%b rv=%b, required 0 1 0", busy_s, ready_s, rv_s);
    end
    @(negedge clk); nrst = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    vectors++;
    if (rvc_s !== r0) begin
      miscompares++;
      $display("FAIL reset_no_result: got %0d pulses, required 0", rvc_s - r0);
    end
    @(posedge clk); #1;
    blk = {};
    for (int i = 0; i < 4; i++) blk.push_back(8'($urandom));
    exp = ref_power(0, blk);
    foreach (blk[i]) send(1'b0, blk[i], 0);
    vs = 1'b0;
    wait_res(1'b0, r0 + 1);
    vectors++;
    if (power_s !== exp) begin
      miscompares++;
      $display("FAIL post_reset_power: got %0d, required %0d", power_s, exp);
    end
  endtask

  task automatic test_default();
    logic [7:0]  blk[$];
    logic [63:0] exp, on_p, off_p;
    real w, ph;
    int r0;
    w  = $acos(27980.0 / 32768.0);
    ph = 6.283185307179586 * real'($urandom_range(0, 999)) / 1000.0;
    for (int t = 0; t < 2; t++) begin
      blk = {};
      for (int n = 0; n < 205; n++)
        blk.push_back(8'($rtoi(128.5 + 100.0 * $sin((w + t * 6.283185307179586 * 3.0 / 205.0) * n + ph))));
      exp = ref_power(27980, blk);
      r0  = rvc_d;
      foreach (blk[i]) send(1'b1, blk[i], 0);
      vd = 1'b0;
      wait_res(1'b1, r0 + 1);
      vectors++;
      if (power_d !== exp) begin
        miscompares++;
        $display("FAIL tone_model[%0d]: got %0d, required %0d", t, power_d, exp);
      end
      if (t == 0) on_p = power_d; else off_p = power_d;
    end
    vectors++;
    if (128'(on_p) < 128'(off_p) * 128'(10000)) begin
      miscompares++;
      $display("FAIL tone_ratio: on=%0d off=%0d, required on >= 10000*off", on_p, off_p);
    end
  endtask

  initial begin
    nrst = 1'b1;
    vs = 1'b0; vd = 1'b0; ss = 8'd128; sd = 8'd128;
    test_reset();
    test_on_bin();
    test_dc_off_bin();
    test_back_pressure();
    test_gaps_reset();
    test_default();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
